// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM stage: op_mem bit positions, FSM states and bus widths.
// Bus widths are functions of the data width so that parameter defaults stay consistent.
package mem_stage_lsu_pkg;

  localparam int OP_MEM      = 0;
  localparam int OP_UNSIGNED = 1;
  localparam int OP_STORE    = 2;
  localparam int OP_WORD     = 3;
  localparam int OP_HALF     = 4;
  localparam int OP_BYTE     = 5;
  localparam int OP_W        = 6;

  localparam int REG_IDX_W = 5;
  localparam int INST_W    = 32;
  localparam int PC_W      = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } lsu_state_e;

  // {is_break, op_mem, wreg_index, wreg_en, inst, pc, inst_valid, src2, src1, alu_result}
  function automatic int ex_ctrl_width(input int dw);
    return 1 + OP_W + REG_IDX_W + 1 + INST_W + PC_W + 1 + 3 * dw;
  endfunction

  // {is_break, inst_valid, wreg_index, wreg_en, inst, pc, result}
  function automatic int mem_ctrl_width(input int dw);
    return 1 + 1 + REG_IDX_W + 1 + INST_W + PC_W + dw;
  endfunction

  // {result, wreg_index, wreg_en}
  function automatic int bypass_width(input int dw);
    return dw + REG_IDX_W + 1;
  endfunction

  // Anything that is neither byte nor half is handled as a word access.
  function automatic logic is_misaligned(input logic is_byte, input logic is_half,
                                         input logic [1:0] addr_lo);
    if (is_byte) return 1'b0;
    if (is_half) return addr_lo[0];
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the core and a DATA_W-wide memory word:
// store data replication / write mask, and load extraction with sign or zero extension.
module mem_lane_align
  import mem_stage_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                        is_store,
  input  logic                        is_unsigned,
  input  logic                        is_half,
  input  logic                        is_byte,
  input  logic [$clog2(DATA_W/8)-1:0] addr_lo,
  input  logic [DATA_W-1:0]           store_data,
  input  logic [DATA_W-1:0]           rdata,
  output logic [DATA_W-1:0]           wdata,
  output logic [DATA_W/8-1:0]         wmask,
  output logic [DATA_W-1:0]           load_data
);
  localparam int NB = DATA_W / 8;
  localparam int AW = $clog2(NB);

  logic [AW-1:0]     lane_off;
  logic [NB-1:0]     base_mask;
  logic [DATA_W-1:0] shifted;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign wdata[gi*8 +: 8] = is_byte ? store_data[7:0] :
                                is_half ? store_data[(gi % 2)*8 +: 8] :
                                          store_data[(gi % 4)*8 +: 8];
    end
  endgenerate

  always_comb begin
    lane_off  = addr_lo;
    base_mask = NB'(15);
    if (is_byte) begin
      base_mask = NB'(1);
    end else if (is_half) begin
      lane_off  = addr_lo & ~AW'(1);
      base_mask = NB'(3);
    end else begin
      lane_off  = addr_lo & ~AW'(3);
    end
    wmask   = is_store ? (base_mask << lane_off) : '0;
    shifted = rdata >> {lane_off, 3'b000};
    if (is_byte)
      load_data = is_unsigned ? DATA_W'(shifted[7:0]) : DATA_W'($signed(shifted[7:0]));
    else if (is_half)
      load_data = is_unsigned ? DATA_W'(shifted[15:0]) : DATA_W'($signed(shifted[15:0]));
    else
      load_data = is_unsigned ? DATA_W'(shifted[31:0]) : DATA_W'($signed(shifted[31:0]));
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage with a variable-latency req/resp data port, a valid/ready output
// register towards WB and a bypass bus that tells ID when the result is usable.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int IN_W     = ex_ctrl_width(DATA_W),
  parameter int OUT_W    = mem_ctrl_width(DATA_W) + 1,
  parameter int MAX_WAIT = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_W-1:0]               in_bus,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              out_bus,
  output logic                          req_valid,
  input  logic                          req_ready,
  output logic [DATA_W-1:0]             req_addr,
  output logic                          req_we,
  output logic [DATA_W/8-1:0]           req_wmask,
  output logic [DATA_W-1:0]             req_wdata,
  input  logic                          resp_valid,
  input  logic [DATA_W-1:0]             resp_rdata,
  output logic [bypass_width(DATA_W):0] bypass,
  output logic                          timeout_err
);
  localparam int NB    = DATA_W / 8;
  localparam int AW    = $clog2(NB);
  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

  logic                 in_is_break, in_wen, in_iv;
  logic [OP_W-1:0]      in_op;
  logic [REG_IDX_W-1:0] in_widx;
  logic [INST_W-1:0]    in_inst;
  logic [PC_W-1:0]      in_pc;
  logic [DATA_W-1:0]    in_src2, in_src1, in_alu;

  assign {in_is_break, in_op, in_widx, in_wen, in_inst, in_pc, in_iv,
          in_src2, in_src1, in_alu} = in_bus;

  logic in_is_mem, in_misalign, in_to_mem, accept;
  assign in_is_mem   = in_op[OP_MEM] & in_iv;
  assign in_misalign = in_is_mem & is_misaligned(in_op[OP_BYTE], in_op[OP_HALF], in_alu[1:0]);
  assign in_to_mem   = in_is_mem & ~in_misalign;
  assign accept      = in_valid & in_ready;

  lsu_state_e state_reg, state_next;

  // Capture register: the instruction currently owned by the memory side.
  logic                 cap_is_break_reg, cap_wen_reg, cap_iv_reg;
  logic [OP_W-1:0]      cap_op_reg;
  logic [REG_IDX_W-1:0] cap_widx_reg;
  logic [INST_W-1:0]    cap_inst_reg;
  logic [PC_W-1:0]      cap_pc_reg;
  logic [DATA_W-1:0]    cap_src2_reg, cap_alu_reg;

  logic                 out_misalign_reg, out_is_break_reg, out_iv_reg, out_wen_reg;
  logic [REG_IDX_W-1:0] out_widx_reg;
  logic [INST_W-1:0]    out_inst_reg;
  logic [PC_W-1:0]      out_pc_reg;
  logic [DATA_W-1:0]    out_result_reg;

  logic [CNT_W-1:0]     wait_cnt_reg;
  logic                 timeout_err_reg;
  logic                 timeout_hit;
  logic [DATA_W-1:0]    load_data;

  logic                 byp_ok, byp_wen;
  logic [DATA_W-1:0]    byp_result;
  logic [REG_IDX_W-1:0] byp_widx;

  // A response in the same cycle as expiry wins over the timeout.
  assign timeout_hit = (state_reg == S_WAIT) & ~resp_valid & (MAX_WAIT != 0) &
                       (wait_cnt_reg == CNT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (accept) state_next = in_to_mem ? S_REQ : S_OUT;
      S_REQ:  if (req_ready) state_next = S_WAIT;
      S_WAIT: if (resp_valid || timeout_hit) state_next = S_OUT;
      S_OUT: begin
        if (accept)         state_next = in_to_mem ? S_REQ : S_OUT;
        else if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    req_valid  = 1'b0;
    out_valid  = 1'b0;
    byp_ok     = 1'b0;
    byp_result = out_result_reg;
    byp_widx   = out_widx_reg;
    byp_wen    = 1'b0;
    case (state_reg)
      S_IDLE: in_ready = 1'b1;
      S_REQ, S_WAIT: begin
        req_valid  = (state_reg == S_REQ);
        byp_result = cap_alu_reg;
        byp_widx   = cap_widx_reg;
        byp_wen    = cap_wen_reg;
      end
      S_OUT: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
        byp_ok    = 1'b1;
        byp_wen   = out_wen_reg;
      end
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_is_break_reg <= 1'b0;
      cap_wen_reg      <= 1'b0;
      cap_iv_reg       <= 1'b0;
      cap_op_reg       <= '0;
      cap_widx_reg     <= '0;
      cap_inst_reg     <= '0;
      cap_pc_reg       <= '0;
      cap_src2_reg     <= '0;
      cap_alu_reg      <= '0;
    end else if (accept) begin
      cap_is_break_reg <= in_is_break;
      cap_wen_reg      <= in_wen;
      cap_iv_reg       <= in_iv;
      cap_op_reg       <= in_op;
      cap_widx_reg     <= in_widx;
      cap_inst_reg     <= in_inst;
      cap_pc_reg       <= in_pc;
      cap_src2_reg     <= in_src2;
      cap_alu_reg      <= in_alu;
    end
  end

  // Non-memory and misaligned ops bypass the memory port and land here directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_misalign_reg <= 1'b0;
      out_is_break_reg <= 1'b0;
      out_iv_reg       <= 1'b0;
      out_wen_reg      <= 1'b0;
      out_widx_reg     <= '0;
      out_inst_reg     <= '0;
      out_pc_reg       <= '0;
      out_result_reg   <= '0;
    end else if (accept && !in_to_mem) begin
      out_misalign_reg <= in_misalign;
      out_is_break_reg <= in_is_break;
      out_iv_reg       <= in_iv;
      out_wen_reg      <= in_wen & ~in_misalign;
      out_widx_reg     <= in_widx;
      out_inst_reg     <= in_inst;
      out_pc_reg       <= in_pc;
      out_result_reg   <= in_alu;
    end else if (state_reg == S_WAIT && (resp_valid || timeout_hit)) begin
      out_misalign_reg <= 1'b0;
      out_is_break_reg <= cap_is_break_reg;
      out_iv_reg       <= cap_iv_reg;
      out_wen_reg      <= cap_wen_reg;
      out_widx_reg     <= cap_widx_reg;
      out_inst_reg     <= cap_inst_reg;
      out_pc_reg       <= cap_pc_reg;
      out_result_reg   <= timeout_hit          ? '0 :
                          cap_op_reg[OP_STORE] ? cap_alu_reg : load_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_reg    <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      if (state_reg == S_REQ && req_ready) wait_cnt_reg <= '0;
      else if (state_reg == S_WAIT)        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
      if (timeout_hit) timeout_err_reg <= 1'b1;
    end
  end

  mem_lane_align #(.DATA_W(DATA_W)) u_lane_align (
    .is_store    (cap_op_reg[OP_STORE]),
    .is_unsigned (cap_op_reg[OP_UNSIGNED]),
    .is_half     (cap_op_reg[OP_HALF]),
    .is_byte     (cap_op_reg[OP_BYTE]),
    .addr_lo     (cap_alu_reg[AW-1:0]),
    .store_data  (cap_src2_reg),
    .rdata       (resp_rdata),
    .wdata       (req_wdata),
    .wmask       (req_wmask),
    .load_data   (load_data)
  );

  assign req_addr    = cap_alu_reg;
  assign req_we      = cap_op_reg[OP_STORE];
  assign timeout_err = timeout_err_reg;
  assign bypass      = {byp_ok, byp_result, byp_widx, byp_wen};
  assign out_bus     = {out_misalign_reg, out_is_break_reg, out_iv_reg, out_widx_reg,
                        out_wen_reg, out_inst_reg, out_pc_reg, out_result_reg};

  logic unused_ok;
  assign unused_ok = ^{in_src1, cap_op_reg[OP_MEM], cap_op_reg[OP_WORD]};

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a table of single transactions plus hand-written
// sequences for handshake stalls, response timeout and reset in the middle of a wait.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  localparam int DATA_W   = 32;
  localparam int IN_W     = ex_ctrl_width(DATA_W);
  localparam int OUT_W    = mem_ctrl_width(DATA_W) + 1;
  localparam int BYP_W    = bypass_width(DATA_W) + 1;
  localparam int MAX_WAIT = 8;

  localparam logic [5:0] OP_ALU = 6'b000000;
  localparam logic [5:0] OP_LB  = 6'b100001;
  localparam logic [5:0] OP_LBU = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b010001;
  localparam logic [5:0] OP_LHU = 6'b010011;
  localparam logic [5:0] OP_LW  = 6'b001001;
  localparam logic [5:0] OP_SB  = 6'b100101;
  localparam logic [5:0] OP_SH  = 6'b010101;
  localparam logic [5:0] OP_SW  = 6'b001101;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid, in_ready;
  logic [IN_W-1:0]     in_bus;
  logic                out_valid, out_ready;
  logic [OUT_W-1:0]    out_bus;
  logic                req_valid, req_ready, req_we;
  logic [DATA_W-1:0]   req_addr, req_wdata;
  logic [DATA_W/8-1:0] req_wmask;
  logic                resp_valid;
  logic [DATA_W-1:0]   resp_rdata;
  logic [BYP_W-1:0]    bypass;
  logic                timeout_err;

  always #5 clk = ~clk;

  mem_stage_lsu #(.DATA_W(DATA_W), .IN_W(IN_W), .OUT_W(OUT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_bus(in_bus),
    .out_valid(out_valid), .out_ready(out_ready), .out_bus(out_bus),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
    .req_wmask(req_wmask), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .bypass(bypass), .timeout_err(timeout_err)
  );

  typedef struct {
    logic [5:0]  op;
    logic        iv;
    logic [31:0] addr;
    logic [31:0] src2;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] exp_result;
    logic        exp_mis;
    logic        exp_req;
    logic        exp_we;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata;
    logic        exp_wen;
  } vec_t;

  vec_t vecs[14];
  int   checks = 0;
  int   errors = 0;
  int   out_hs = 0;

  always @(posedge clk) if (out_valid && out_ready) out_hs <= out_hs + 1;

  function automatic logic [IN_W-1:0] mk_bus(input logic [5:0] op, input logic iv,
                                             input logic [4:0] widx, input logic [31:0] src2,
                                             input logic [31:0] alu);
    return {1'b0, op, widx, 1'b1, 32'h0000_0013, 32'h8000_0100, iv, src2, 32'h0, alu};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int hs0;
    hs0 = out_hs;
    in_bus   = mk_bus(v.op, v.iv, 5'(idx + 1), v.src2, v.addr);
    in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    step();
    in_valid = 1'b0;
    if (v.exp_req) begin
      chk("req_valid", req_valid, 1);
      chk("req_addr", req_addr, v.addr);
      chk("req_we", req_we, v.exp_we);
      if (v.exp_we) begin
        chk("req_wmask", req_wmask, v.exp_mask);
        chk("req_wdata", req_wdata, v.exp_wdata);
      end
      chk("byp_ok_req", bypass[BYP_W-1], 0);
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      chk("req_drop", req_valid, 0);
      repeat (v.delay) step();
      resp_valid = 1'b1;
      resp_rdata = v.rdata;
      step();
      resp_valid = 1'b0;
    end else begin
      chk("no_req", req_valid, 0);
    end
    chk("out_valid", out_valid, 1);
    chk("result", out_bus[31:0], v.exp_result);
    chk("misalign", out_bus[OUT_W-1], v.exp_mis);
    chk("wreg_en", out_bus[96], v.exp_wen);
    chk("wreg_index", out_bus[101:97], 5'(idx + 1));
    chk("byp_ok_out", bypass[BYP_W-1], 1);
    chk("byp_result", bypass[BYP_W-2 -: 32], v.exp_result);
    step();
    chk("out_drained", out_valid, 0);
    chk("one_handshake", out_hs, hs0 + 1);
    $display("TXN %0d op=%b addr=%h result=%h misalign=%0b", idx, v.op, v.addr,
             out_bus[31:0], out_bus[OUT_W-1]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    //        op      iv    addr          src2          rdata         dly result        mis   req   we    mask  wdata         wen
    vecs[0]  = '{OP_ALU, 1'b1, 32'h0000_1234, 32'h0,        32'h0,        0, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        1'b1};
    vecs[1]  = '{OP_LB,  1'b1, 32'h0000_1003, 32'h0,        32'h80FF_0000, 3, 32'hFFFF_FF80, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1};
    vecs[2]  = '{OP_LBU, 1'b1, 32'h0000_1003, 32'h0,        32'h80FF_0000, 3, 32'h0000_0080, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1};
    vecs[3]  = '{OP_SH,  1'b1, 32'h0000_2002, 32'hABCD_BEEF, 32'h0,        1, 32'h0000_2002, 1'b0, 1'b1, 1'b1, 4'hC, 32'hBEEF_BEEF, 1'b1};
    vecs[4]  = '{OP_LW,  1'b1, 32'h0000_1001, 32'h0,        32'h0,        0, 32'h0000_1001, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        1'b0};
    vecs[5]  = '{OP_LH,  1'b1, 32'h0000_1002, 32'h0,        32'h8001_1234, 2, 32'hFFFF_8001, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1};
    vecs[6]  = '{OP_LHU, 1'b1, 32'h0000_1002, 32'h0,        32'h8001_1234, 0, 32'h0000_8001, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1};
    vecs[7]  = '{OP_LW,  1'b1, 32'h0000_1004, 32'h0,        32'hCAFE_BABE, 1, 32'hCAFE_BABE, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1};
    vecs[8]  = '{OP_SB,  1'b1, 32'h0000_3001, 32'h1234_5678, 32'h0,        0, 32'h0000_3001, 1'b0, 1'b1, 1'b1, 4'h2, 32'h7878_7878, 1'b1};
    vecs[9]  = '{OP_SW,  1'b1, 32'h0000_3000, 32'hA5A5_0F0F, 32'h0,        2, 32'h0000_3000, 1'b0, 1'b1, 1'b1, 4'hF, 32'hA5A5_0F0F, 1'b1};
    vecs[10] = '{OP_LH,  1'b1, 32'h0000_1003, 32'h0,        32'h0,        0, 32'h0000_1003, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        1'b0};
    vecs[11] = '{OP_LW,  1'b0, 32'h0000_1000, 32'h0,        32'h0,        0, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        1'b1};
    vecs[12] = '{OP_SW,  1'b1, 32'h0000_3002, 32'h1111_2222, 32'h0,        0, 32'h0000_3002, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        1'b0};
    vecs[13] = '{OP_LB,  1'b1, 32'h0000_1000, 32'h0,        32'h0000_00F0, 0, 32'hFFFF_FFF0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1};

    reset      = 1'b0;
    in_valid   = 1'b0;
    in_bus     = '0;
    out_ready  = 1'b1;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_out_bus", out_bus, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_byp_wen", bypass[0], 0);
    @(negedge clk) reset = 1'b1;
    step();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Request stalled 4 cycles, output stalled 2 cycles, then OUT -> REQ back to back
    begin
      int hs0;
      hs0      = out_hs;
      in_bus   = mk_bus(OP_LW, 1'b1, 5'd20, 32'h0, 32'h0000_4000);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
        chk("stall_req_valid", req_valid, 1);
        chk("stall_req_addr", req_addr, 32'h0000_4000);
        chk("stall_byp_ok", bypass[BYP_W-1], 0);
        step();
      end
      req_ready = 1'b1;
      step();
      req_ready  = 1'b0;
      resp_valid = 1'b1;
      resp_rdata = 32'h1111_2222;
      out_ready  = 1'b0;
      step();
      resp_valid = 1'b0;
      in_bus     = mk_bus(OP_LBU, 1'b1, 5'd21, 32'h0, 32'h0000_4001);
      in_valid   = 1'b1;
      for (int k = 0; k < 2; k++) begin
        chk("hold_out_valid", out_valid, 1);
        chk("hold_result", out_bus[31:0], 32'h1111_2222);
        chk("hold_in_ready", in_ready, 0);
        step();
      end
      out_ready = 1'b1;
      #1;
      chk("drain_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("b2b_out_valid", out_valid, 0);
      chk("b2b_req_valid", req_valid, 1);
      chk("b2b_req_addr", req_addr, 32'h0000_4001);
      chk("b2b_hs_first", out_hs, hs0 + 1);
      req_ready = 1'b1;
      step();
      req_ready  = 1'b0;
      resp_valid = 1'b1;
      resp_rdata = 32'h0000_AB00;
      step();
      resp_valid = 1'b0;
      chk("b2b_result", out_bus[31:0], 32'h0000_00AB);
      chk("b2b_wreg_index", out_bus[101:97], 5'd21);
      step();
      chk("b2b_hs_total", out_hs, hs0 + 2);
      chk("b2b_idle", out_valid, 0);
      $display("TXN stall_seq handshakes=%0d", out_hs - hs0);
    end

    // Response never arrives: timeout after MAX_WAIT wait cycles
    in_bus   = mk_bus(OP_LW, 1'b1, 5'd3, 32'h0, 32'h0000_5000);
    in_valid = 1'b1;
    step();
    in_valid  = 1'b0;
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    repeat (MAX_WAIT - 1) step();
    chk("to_not_yet", timeout_err, 0);
    chk("to_no_out", out_valid, 0);
    chk("to_byp_ok", bypass[BYP_W-1], 0);
    step();
    chk("to_err", timeout_err, 1);
    chk("to_out_valid", out_valid, 1);
    chk("to_result", out_bus[31:0], 32'h0);
    step();
    chk("to_sticky", timeout_err, 1);
    chk("to_idle", out_valid, 0);
    $display("TXN timeout timeout_err=%0b", timeout_err);

    // Reset asserted while waiting for a response
    in_bus   = mk_bus(OP_LW, 1'b1, 5'd4, 32'h0, 32'h0000_6000);
    in_valid = 1'b1;
    step();
    in_valid  = 1'b0;
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_req_valid", req_valid, 0);
    chk("mid_rst_out_bus", out_bus, 0);
    chk("mid_rst_timeout", timeout_err, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_bypass", bypass, 0);
    @(negedge clk) reset = 1'b1;
    step();
    resp_valid = 1'b1;
    resp_rdata = 32'hDEAD_BEEF;
    step();
    resp_valid = 1'b0;
    chk("stray_resp_ignored", out_valid, 0);
    $display("TXN reset_in_wait out_valid=%0b", out_valid);
    run_vec(vecs[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
